rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Write-port arbiter and pending-write scoreboard for the three-ported register file. The register file has one write port, shared by two writeback sources: port 0, the in-order pipeline writeback stage, and port 1, the long-latency unit (mul/div/load miss). The arbiter picks one source per cycle and drives the write port from a registered output stage. An optional scoreboard tracks destination registers with an outstanding port-1 write, so decode can stall on RAW hazards.

## Interface
Parameters (widths come from the shared defines):
- `XLEN`: default 32; data width.
- `RFIDX_WIDTH`: default 5; register index width.
- `ADDR_SIZE`: default 32; PC width, forwarded for writeback trace.
- `RFREG_NUM`: default 32; number of architectural registers.

Ports:
- `clk`  in  1  single clock; all state on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `wb0_valid`  in  1  pipeline writeback request.
- `wb0_ready`  out  1  port 0 accepted this cycle.
- `wb0_rd`  in  `RFIDX_WIDTH`  port 0 destination.
- `wb0_data`  in  `XLEN`  port 0 data.
- `wb0_pc`  in  `ADDR_SIZE`  port 0 PC.
- `wb1_valid`, `wb1_ready`, `wb1_rd`, `wb1_data`, `wb1_pc`: same as port 0, for the long-latency unit.
- `we3`  out  1  register-file write enable.
- `wa3`  out  `RFIDX_WIDTH`  write address.
- `wd3`  out  `XLEN`  write data.
- `pc`  out  `ADDR_SIZE`  PC of the committed write.
- `alloc_valid`  in  1  decode issued an instruction to the long-latency unit.
- `alloc_rd`  in  `RFIDX_WIDTH`  its destination.
- `ra1`, `ra2`  in  `RFIDX_WIDTH`  decode source indices.
- `busy1`, `busy2`  out  1  source has a pending port-1 write.
- `busy_any`  out  1  OR of all scoreboard bits.

## Operation
- Handshake: a request transfers when `valid && ready`.
  - `ready` is combinational from the `valid` inputs and the arbiter state; it never depends on `ready`.
  - A requester must hold `rd`, `data` and `pc` stable while `valid` is high and `ready` is low.
- Arbitration is round-robin with a 1-bit `last` pointer.
  - Only one port valid: that port is granted.
  - Both ports valid: the port not equal to `last` is granted.
  - `last` updates to the granted port on each transfer.
  - Reset sets `last = 1`, so port 0 wins the first conflict.
- At most one `ready` is high per cycle; neither is high when no port is valid.
- Output stage:
  - On a transfer, `wa3`, `wd3` and `pc` register the granted fields on the next posedge.
  - `we3` registers `1` only if the granted `rd != 0`. A write to x0 is consumed, `we3` stays 0.
  - With no transfer, `we3` registers 0; `wa3`, `wd3` and `pc` hold their values.
- Scoreboard: `busy[RFREG_NUM-1:0]`.
  - Set: `alloc_valid && alloc_rd != 0` sets `busy[alloc_rd]`.
  - Clear: a port-1 transfer with `wb1_rd == r` clears `busy[r]`.
  - Set and clear of the same index in one cycle: set wins (a new allocation supersedes).
  - Port-0 transfers never touch the scoreboard.
  - `busy[0]` is constant 0.
  - `busy1 = busy[ra1]`, `busy2 = busy[ra2]`, both combinational.

## Timing
- Request to `we3`: 1 cycle. Transfer at edge N, `we3`/`wa3`/`wd3` valid from edge N+1 until edge N+2.
- The register file samples on the following negedge, inside the same cycle.
- Throughput: one write per cycle.
- Worst-case wait for a continuously valid requester: 1 cycle.
- Scoreboard update is visible on `busy1`/`busy2` one cycle after the alloc or clear edge; there is no bypass.
- Reset, asserted at any time, asynchronously forces:
  - `we3 = 0`, `wa3 = 0`, `wd3 = 0`, `pc = 0`;
  - `last = 1`;
  - all `busy` bits 0, hence `busy1`, `busy2`, `busy_any` are 0.
- A request in flight during reset is dropped; requesters must re-present it.
- `wb*_ready` are combinational and are 0 whenever the valids are 0.

## Configuration
- `RF_WB_SCOREBOARD_EN` defined: scoreboard storage and its logic are compiled in, as described above.
- Undefined:
  - no `busy` storage;
  - `busy1`, `busy2`, `busy_any` tied 0;
  - `alloc_valid`, `alloc_rd`, `ra1`, `ra2` ignored.
- Arbitration and the output stage are identical in both builds.

## Structure
- `XLEN`, `RFIDX_WIDTH`, `ADDR_SIZE`, `RFREG_NUM` and the port-index constants `WB_PORT_PIPE` = 0 and `WB_PORT_LLU` = 1 live in `xgriscv_defines.v`.
- One sub-module is natural: `rf_scoreboard`, which holds the busy vector, set/clear logic and the two read ports. It is instantiated only under `RF_WB_SCOREBOARD_EN`.
- The round-robin arbiter and the output register stay in the top module.

## Test plan
- Reset, then `wb0_valid=1`, `rd=5`, `data=0x1234`, `pc=0x100` for one cycle -> `wb0_ready=1` that cycle; next cycle `we3=1`, `wa3=5`, `wd3=0x1234`, `pc=0x100`; the cycle after, `we3=0`.
- Both ports valid for 4 cycles after reset (rd 1 and 2) -> grant order 0, 1, 0, 1; `we3` high 4 consecutive cycles with `wa3` = 1, 2, 1, 2.
- `wb1` write to rd=0 with data 0xFFFF -> `wb1_ready=1`; next cycle `we3=0`; the scoreboard is unchanged.
- `alloc_valid`, `alloc_rd=7`, then `ra1=7` -> `busy1=1`, `busy_any=1`. A later port-1 transfer with rd=7 -> `busy1=0` the next cycle.
- Same cycle: `alloc_rd=9` and a port-1 transfer with rd=9 while `busy[9]=1` -> `busy[9]` stays 1.
- Assert reset mid-stream with `we3=1` and `busy[3]=1` -> `we3=0` and `busy2=0` (with `ra2=3`) immediately, before the next clock edge.
- Build without `RF_WB_SCOREBOARD_EN`, `alloc_rd=4`, `ra1=4` -> `busy1=0` always.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Port indices identify the two writeback sources competing for the RF write port.
package rf_wb_arbiter_pkg;

  // Writeback source identifiers; also the encoding of the round-robin pointer
  typedef enum logic {
    WB_PORT_PIPE = 1'b0,
    WB_PORT_LLU  = 1'b1
  } wb_port_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register for
// writes outstanding on the long-latency writeback port. x0 is never busy.
module rf_scoreboard #(
  parameter int RFIDX_WIDTH = 5,
  parameter int RFREG_NUM   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   set_valid,
  input  logic [RFIDX_WIDTH-1:0] set_rd,
  input  logic                   clr_valid,
  input  logic [RFIDX_WIDTH-1:0] clr_rd,
  input  logic [RFIDX_WIDTH-1:0] ra1,
  input  logic [RFIDX_WIDTH-1:0] ra2,
  output logic                   busy1,
  output logic                   busy2,
  output logic                   busy_any
);

  // Bit 0 is not stored at all, so x0 always reads as not busy
  logic [RFREG_NUM-1:1] busy;

  // Set on allocation, clear on long-latency writeback; a same-cycle set wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < RFREG_NUM; i++) begin
        if (set_valid && set_rd == RFIDX_WIDTH'(i))
          busy[i] <= 1'b1;
        else if (clr_valid && clr_rd == RFIDX_WIDTH'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  // Combinational read ports; indices with no stored bit read as 0
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 1; i < RFREG_NUM; i++) begin
      if (ra1 == RFIDX_WIDTH'(i)) busy1 = busy[i];
      if (ra2 == RFIDX_WIDTH'(i)) busy2 = busy[i];
    end
  end

  assign busy_any = |busy;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: round-robin between the pipeline writeback
// (port 0) and the long-latency unit (port 1), with a registered write stage.
// Optional pending-write scoreboard compiled in when RF_WB_SCOREBOARD_EN is defined;
// otherwise busy1/busy2/busy_any are tied low and the alloc/read inputs are ignored.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int ADDR_SIZE   = 32,
  parameter int RFREG_NUM   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb0_valid,
  output logic                   wb0_ready,
  input  logic [RFIDX_WIDTH-1:0] wb0_rd,
  input  logic [XLEN-1:0]        wb0_data,
  input  logic [ADDR_SIZE-1:0]   wb0_pc,
  input  logic                   wb1_valid,
  output logic                   wb1_ready,
  input  logic [RFIDX_WIDTH-1:0] wb1_rd,
  input  logic [XLEN-1:0]        wb1_data,
  input  logic [ADDR_SIZE-1:0]   wb1_pc,
  output logic                   we3,
  output logic [RFIDX_WIDTH-1:0] wa3,
  output logic [XLEN-1:0]        wd3,
  output logic [ADDR_SIZE-1:0]   pc,
  input  logic                   alloc_valid,
  input  logic [RFIDX_WIDTH-1:0] alloc_rd,
  input  logic [RFIDX_WIDTH-1:0] ra1,
  input  logic [RFIDX_WIDTH-1:0] ra2,
  output logic                   busy1,
  output logic                   busy2,
  output logic                   busy_any
);

  wb_port_e               last;
  logic                   gnt0_p0, gnt1_p0, vld_p0;
  logic [RFIDX_WIDTH-1:0] rd_p0;
  logic [XLEN-1:0]        data_p0;
  logic [ADDR_SIZE-1:0]   pc_p0;

  logic                   vld_p1;
  logic [RFIDX_WIDTH-1:0] wa_p1;
  logic [XLEN-1:0]        wd_p1;
  logic [ADDR_SIZE-1:0]   pc_p1;

  // ---- stage p0: arbitration (combinational from valids and last) ----
  // A lone requester always wins; on conflict the port that did not win last time wins
  always_comb begin
    gnt0_p0 = wb0_valid && (!wb1_valid || last == WB_PORT_LLU);
    gnt1_p0 = wb1_valid && (!wb0_valid || last == WB_PORT_PIPE);
    vld_p0  = gnt0_p0 || gnt1_p0;
    rd_p0   = gnt1_p0 ? wb1_rd   : wb0_rd;
    data_p0 = gnt1_p0 ? wb1_data : wb0_data;
    pc_p0   = gnt1_p0 ? wb1_pc   : wb0_pc;
  end

  assign wb0_ready = gnt0_p0;
  assign wb1_ready = gnt1_p0;

  // Round-robin pointer follows the most recent transfer; reset favours port 0 first
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        last <= WB_PORT_LLU;
    else if (gnt0_p0) last <= WB_PORT_PIPE;
    else if (gnt1_p0) last <= WB_PORT_LLU;
  end

  // ---- stage p1: registered write port ----
  // Writes to x0 are consumed without raising the enable; fields hold when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      wa_p1  <= '0;
      wd_p1  <= '0;
      pc_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0 && (rd_p0 != '0);
      if (vld_p0) begin
        wa_p1 <= rd_p0;
        wd_p1 <= data_p0;
        pc_p1 <= pc_p0;
      end
    end
  end

  assign we3 = vld_p1;
  assign wa3 = wa_p1;
  assign wd3 = wd_p1;
  assign pc  = pc_p1;

`ifdef RF_WB_SCOREBOARD_EN
  rf_scoreboard #(
    .RFIDX_WIDTH (RFIDX_WIDTH),
    .RFREG_NUM   (RFREG_NUM)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_valid (alloc_valid),
    .set_rd    (alloc_rd),
    .clr_valid (gnt1_p0),
    .clr_rd    (wb1_rd),
    .ra1       (ra1),
    .ra2       (ra2),
    .busy1     (busy1),
    .busy2     (busy2),
    .busy_any  (busy_any)
  );
`else
  // Scoreboard absent: decode never sees a pending write
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{alloc_valid, alloc_rd, ra1, ra2};
  assign busy1    = 1'b0;
  assign busy2    = 1'b0;
  assign busy_any = 1'b0;
`endif

endmodule
